// File: rtl/req_conditioner.sv
// -----------------------------------------------------------------------------
// req_conditioner
//
// Front end for the traffic-light controller's pedestrian and emergency
// push buttons. Each raw button is synchronised (two flops), debounced, and
// turned into a single press event on the debounced rising edge. Press events
// become level requests that hold until the controller acknowledges them.
// Emergency requests take priority over pedestrian requests, and pedestrian
// presses are rejected during a hold-off window that follows each pedestrian
// acknowledge. Rejected pedestrian presses are counted (saturating).
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive stable cycles before the debounced level moves
//                    (1..255)
//   PED_HOLDOFF      hold-off length in cycles after a pedestrian ack (0 = off)
//   DROP_W           width of the rejected-press counter
//
// Ports:
//   clk             system clock, rising edge
//   reset           synchronous active-low reset
//   ped_raw         raw pedestrian button (asynchronous, bouncy)
//   em_raw          raw emergency button (asynchronous, bouncy)
//   ped_ack         one-cycle pulse: pedestrian request serviced
//   em_ack          one-cycle pulse: emergency request serviced
//   ped_button      pedestrian request level
//   em_button       emergency request level
//   holdoff_active  high while the hold-off counter is non-zero
//   ped_drop_count  saturating count of rejected pedestrian presses
// -----------------------------------------------------------------------------
module req_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned PED_HOLDOFF     = 200,
  parameter int unsigned DROP_W          = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ped_raw,
  input  logic              em_raw,
  input  logic              ped_ack,
  input  logic              em_ack,
  output logic              ped_button,
  output logic              em_button,
  output logic              holdoff_active,
  output logic [DROP_W-1:0] ped_drop_count
);

  // Channel indices into the per-button vectors.
  localparam int CH_PED = 0;
  localparam int CH_EM  = 1;

  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam int         HO_W    = (PED_HOLDOFF > 0) ? $clog2(PED_HOLDOFF + 1) : 1;
  localparam logic [HO_W-1:0] HO_LOAD = HO_W'(PED_HOLDOFF);

  // Synchroniser and debounce state, one bit/counter per channel.
  logic [1:0] sync1_q, sync2_q;
  logic [1:0] db_q, db_d;
  logic [1:0] db_prev_q;
  logic [7:0] db_cnt_q [2];
  logic [7:0] db_cnt_d [2];

  // Request and hold-off state.
  logic              ped_button_q, ped_button_d;
  logic              em_button_q, em_button_d;
  logic [HO_W-1:0]   holdoff_cnt_q, holdoff_cnt_d;
  logic              holdoff_active_q, holdoff_active_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  logic [1:0] press;
  logic       ped_press, em_press;
  logic       ped_accept, ped_reject, ped_ack_valid;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the block leaves it unassigned and no latch is inferred.
    for (int ch = 0; ch < 2; ch++) begin
      db_d[ch]     = db_q[ch];
      db_cnt_d[ch] = '0;
      if (sync2_q[ch] != db_q[ch]) begin
        if (db_cnt_q[ch] == DB_LAST) begin
          db_d[ch]     = sync2_q[ch];
          db_cnt_d[ch] = '0;
        end else begin
          db_cnt_d[ch] = db_cnt_q[ch] + 8'd1;
        end
      end
    end

    // A press is the debounced level rising; releases produce nothing.
    press     = db_q & ~db_prev_q;
    ped_press = press[CH_PED];
    em_press  = press[CH_EM];

    // Emergency: a new press wins over a coincident ack so it is never lost.
    em_button_d = em_button_q;
    if (em_press) begin
      em_button_d = 1'b1;
    end else if (em_ack) begin
      em_button_d = 1'b0;
    end

    // An ack only counts while the request it answers is actually pending;
    // stray acks neither clear anything nor start the hold-off window.
    ped_ack_valid = ped_ack && ped_button_q;

    // A valid ack implies ped_button_q==1, so a press coinciding with it is
    // rejected by the ped_button_q term below.
    ped_accept = ped_press && !holdoff_active_q && !ped_button_q &&
                 !em_button_q && !em_press;
    ped_reject = ped_press && !ped_accept;

    ped_button_d = ped_button_q;
    if (ped_ack_valid) begin
      ped_button_d = 1'b0;
    end
    if (ped_accept) begin
      ped_button_d = 1'b1;
    end

    holdoff_cnt_d = holdoff_cnt_q;
    if (ped_ack_valid) begin
      holdoff_cnt_d = HO_LOAD;
    end else if (holdoff_cnt_q != '0) begin
      holdoff_cnt_d = holdoff_cnt_q - 1'b1;
    end
    // Registered copy of (counter != 0) so the flag comes straight off a flop.
    holdoff_active_d = (holdoff_cnt_d != '0);

    drop_cnt_d = drop_cnt_q;
    if (ped_reject && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q          <= '0;
      sync2_q          <= '0;
      db_q             <= '0;
      db_prev_q        <= '0;
      db_cnt_q[0]      <= '0;
      db_cnt_q[1]      <= '0;
      ped_button_q     <= 1'b0;
      em_button_q      <= 1'b0;
      holdoff_cnt_q    <= '0;
      holdoff_active_q <= 1'b0;
      drop_cnt_q       <= '0;
    end else begin
      // Two-flop synchroniser: raw buttons are asynchronous to clk.
      sync1_q          <= {em_raw, ped_raw};
      sync2_q          <= sync1_q;
      db_q             <= db_d;
      db_prev_q        <= db_q;
      db_cnt_q[0]      <= db_cnt_d[0];
      db_cnt_q[1]      <= db_cnt_d[1];
      ped_button_q     <= ped_button_d;
      em_button_q      <= em_button_d;
      holdoff_cnt_q    <= holdoff_cnt_d;
      holdoff_active_q <= holdoff_active_d;
      drop_cnt_q       <= drop_cnt_d;
    end
  end

  assign ped_button     = ped_button_q;
  assign em_button      = em_button_q;
  assign holdoff_active = holdoff_active_q;
  assign ped_drop_count = drop_cnt_q;

endmodule

// File: tb/tb_req_conditioner.sv
// -----------------------------------------------------------------------------
// tb_req_conditioner
//
// Directed bench for req_conditioner. Two instances share all inputs: the main
// one (DROP_W=8) and a narrow one (DROP_W=2) whose drop counter must track the
// main counter until it saturates at 3. Inputs change 1 ns after a rising edge
// and outputs are checked at that same point, so "after edge En" below means
// the value registered at En.
// -----------------------------------------------------------------------------
module tb_req_conditioner;

  logic       clk;
  logic       reset;
  logic       ped_raw, em_raw, ped_ack, em_ack;
  logic       ped_button, em_button, holdoff_active;
  logic [7:0] ped_drop_count;
  logic       s_ped_button, s_em_button, s_holdoff_active;
  logic [1:0] s_ped_drop_count;

  int n_cmp;
  int n_fail;

  req_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .PED_HOLDOFF    (20),
    .DROP_W         (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .ped_raw       (ped_raw),
    .em_raw        (em_raw),
    .ped_ack       (ped_ack),
    .em_ack        (em_ack),
    .ped_button    (ped_button),
    .em_button     (em_button),
    .holdoff_active(holdoff_active),
    .ped_drop_count(ped_drop_count)
  );

  req_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .PED_HOLDOFF    (20),
    .DROP_W         (2)
  ) dut_sat (
    .clk           (clk),
    .reset         (reset),
    .ped_raw       (ped_raw),
    .em_raw        (em_raw),
    .ped_ack       (ped_ack),
    .em_ack        (em_ack),
    .ped_button    (s_ped_button),
    .em_button     (s_em_button),
    .holdoff_active(s_holdoff_active),
    .ped_drop_count(s_ped_drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reset held for one edge with both raw buttons low.
  task automatic quiet_reset();
    ped_raw = 1'b0;
    em_raw  = 1'b0;
    reset   = 1'b0;
    tick(1);
    reset   = 1'b1;
  endtask

  // Reset, then a clean emergency press and its ack with exact latency.
  task automatic test_reset();
    reset = 1'b0;
    tick(3);
    n_cmp++; if (ped_button !== 1'b0) begin n_fail++; $display("FAIL rst_ped_button got %b exp 0", ped_button); end
    n_cmp++; if (em_button !== 1'b0) begin n_fail++; $display("FAIL rst_em_button got %b exp 0", em_button); end
    n_cmp++; if (holdoff_active !== 1'b0) begin n_fail++; $display("FAIL rst_holdoff got %b exp 0", holdoff_active); end
    n_cmp++; if (ped_drop_count !== 8'd0) begin n_fail++; $display("FAIL rst_drop got %0d exp 0", ped_drop_count); end
    reset  = 1'b1;
    em_raw = 1'b1;
    tick(6);                                   // E0..E5
    n_cmp++; if (em_button !== 1'b0) begin n_fail++; $display("FAIL em_early got %b exp 0", em_button); end
    tick(1);                                   // E6
    n_cmp++; if (em_button !== 1'b1) begin n_fail++; $display("FAIL em_rise got %b exp 1", em_button); end
    tick(3);                                   // E7..E9
    n_cmp++; if (em_button !== 1'b1) begin n_fail++; $display("FAIL em_hold got %b exp 1", em_button); end
    em_ack = 1'b1;
    tick(1);                                   // E10
    em_ack = 1'b0;
    n_cmp++; if (em_button !== 1'b0) begin n_fail++; $display("FAIL em_ack_clear got %b exp 0", em_button); end
  endtask

  // Bouncing pedestrian press: high 3, low 1, then stable high.
  task automatic test_bounce();
    em_raw  = 1'b0;
    ped_raw = 1'b1;
    tick(3);                                   // A0..A2
    ped_raw = 1'b0;
    tick(1);                                   // A3
    ped_raw = 1'b1;
    tick(6);                                   // A4..A9
    n_cmp++; if (ped_button !== 1'b0) begin n_fail++; $display("FAIL bounce_early got %b exp 0", ped_button); end
    tick(1);                                   // A10
    n_cmp++; if (ped_button !== 1'b1) begin n_fail++; $display("FAIL bounce_rise got %b exp 1", ped_button); end
    n_cmp++; if (ped_drop_count !== 8'd0) begin n_fail++; $display("FAIL bounce_drop got %0d exp 0", ped_drop_count); end
  endtask

  // Hold-off window after a pedestrian ack: 20 cycles, press inside rejected.
  task automatic test_holdoff();
    ped_ack = 1'b1;
    ped_raw = 1'b0;
    tick(1);                                   // H0
    ped_ack = 1'b0;
    n_cmp++; if (ped_button !== 1'b0) begin n_fail++; $display("FAIL ack_clear got %b exp 0", ped_button); end
    n_cmp++; if (holdoff_active !== 1'b1) begin n_fail++; $display("FAIL holdoff_start got %b exp 1", holdoff_active); end
    tick(5);                                   // H1..H5
    ped_raw = 1'b1;
    tick(7);                                   // H6..H12, press decided at H12
    n_cmp++; if (ped_button !== 1'b0) begin n_fail++; $display("FAIL holdoff_reject got %b exp 0", ped_button); end
    n_cmp++; if (ped_drop_count !== 8'd1) begin n_fail++; $display("FAIL holdoff_drop got %0d exp 1", ped_drop_count); end
    tick(7);                                   // H19
    n_cmp++; if (holdoff_active !== 1'b1) begin n_fail++; $display("FAIL holdoff_last got %b exp 1", holdoff_active); end
    tick(1);                                   // H20
    n_cmp++; if (holdoff_active !== 1'b0) begin n_fail++; $display("FAIL holdoff_end got %b exp 0", holdoff_active); end
    ped_raw = 1'b0;
    tick(6);
    ped_raw = 1'b1;
    tick(6);
    n_cmp++; if (ped_button !== 1'b0) begin n_fail++; $display("FAIL third_early got %b exp 0", ped_button); end
    tick(1);
    n_cmp++; if (ped_button !== 1'b1) begin n_fail++; $display("FAIL third_accept got %b exp 1", ped_button); end
    n_cmp++; if (ped_drop_count !== 8'd1) begin n_fail++; $display("FAIL third_drop got %0d exp 1", ped_drop_count); end
  endtask

  // Pedestrian and emergency pressed together: emergency wins.
  task automatic test_simultaneous();
    quiet_reset();
    n_cmp++; if (ped_button !== 1'b0 || em_button !== 1'b0) begin n_fail++; $display("FAIL sim_reset got ped=%b em=%b exp 0 0", ped_button, em_button); end
    ped_raw = 1'b1;
    em_raw  = 1'b1;
    tick(7);
    n_cmp++; if (em_button !== 1'b1) begin n_fail++; $display("FAIL sim_em got %b exp 1", em_button); end
    n_cmp++; if (ped_button !== 1'b0) begin n_fail++; $display("FAIL sim_ped got %b exp 0", ped_button); end
    n_cmp++; if (ped_drop_count !== 8'd1) begin n_fail++; $display("FAIL sim_drop got %0d exp 1", ped_drop_count); end
    n_cmp++; if (s_ped_drop_count !== 2'd1) begin n_fail++; $display("FAIL sim_drop_narrow got %0d exp 1", s_ped_drop_count); end
    em_ack = 1'b1;
    tick(1);
    em_ack = 1'b0;
    n_cmp++; if (em_button !== 1'b0) begin n_fail++; $display("FAIL sim_em_ack got %b exp 0", em_button); end
    ped_raw = 1'b0;
    tick(6);
    ped_raw = 1'b1;
    tick(7);
    n_cmp++; if (ped_button !== 1'b1) begin n_fail++; $display("FAIL sim_ped_after got %b exp 1", ped_button); end
    n_cmp++; if (ped_drop_count !== 8'd1) begin n_fail++; $display("FAIL sim_drop_after got %0d exp 1", ped_drop_count); end
  endtask

  // Stray ped_ack, and a new emergency press coinciding with em_ack.
  task automatic test_ack_corners();
    quiet_reset();
    ped_ack = 1'b1;
    tick(1);
    ped_ack = 1'b0;
    n_cmp++; if (holdoff_active !== 1'b0) begin n_fail++; $display("FAIL stray_ack got %b exp 0", holdoff_active); end
    tick(1);
    n_cmp++; if (holdoff_active !== 1'b0) begin n_fail++; $display("FAIL stray_ack_late got %b exp 0", holdoff_active); end
    em_raw = 1'b1;
    tick(7);
    n_cmp++; if (em_button !== 1'b1) begin n_fail++; $display("FAIL em_first got %b exp 1", em_button); end
    em_raw = 1'b0;
    tick(6);
    em_raw = 1'b1;
    tick(6);                                   // second press event now pending
    em_ack = 1'b1;
    tick(1);
    em_ack = 1'b0;
    n_cmp++; if (em_button !== 1'b1) begin n_fail++; $display("FAIL em_set_priority got %b exp 1", em_button); end
    em_ack = 1'b1;
    tick(1);
    em_ack = 1'b0;
    n_cmp++; if (em_button !== 1'b0) begin n_fail++; $display("FAIL em_second_ack got %b exp 0", em_button); end
  endtask

  // Saturating drop counter, both requests high, reset mid-request and
  // buttons held through reset release.
  task automatic test_saturate_and_reset();
    quiet_reset();
    ped_raw = 1'b1;
    tick(7);
    n_cmp++; if (ped_button !== 1'b1) begin n_fail++; $display("FAIL sat_accept got %b exp 1", ped_button); end
    for (int i = 0; i < 5; i++) begin
      ped_raw = 1'b0;
      tick(6);
      ped_raw = 1'b1;
      tick(7);
    end
    n_cmp++; if (ped_drop_count !== 8'd5) begin n_fail++; $display("FAIL sat_drop_wide got %0d exp 5", ped_drop_count); end
    n_cmp++; if (s_ped_drop_count !== 2'd3) begin n_fail++; $display("FAIL sat_drop_narrow got %0d exp 3", s_ped_drop_count); end
    em_raw = 1'b1;
    tick(7);
    n_cmp++; if (em_button !== 1'b1 || ped_button !== 1'b1) begin n_fail++; $display("FAIL both_high got em=%b ped=%b exp 1 1", em_button, ped_button); end
    reset = 1'b0;
    tick(1);
    n_cmp++; if (ped_button !== 1'b0 || em_button !== 1'b0) begin n_fail++; $display("FAIL midrst_req got ped=%b em=%b exp 0 0", ped_button, em_button); end
    n_cmp++; if (ped_drop_count !== 8'd0 || s_ped_drop_count !== 2'd0) begin n_fail++; $display("FAIL midrst_drop got %0d/%0d exp 0/0", ped_drop_count, s_ped_drop_count); end
    reset = 1'b1;
    tick(6);
    n_cmp++; if (em_button !== 1'b0) begin n_fail++; $display("FAIL held_early got %b exp 0", em_button); end
    tick(1);
    n_cmp++; if (em_button !== 1'b1) begin n_fail++; $display("FAIL held_em got %b exp 1", em_button); end
    n_cmp++; if (ped_button !== 1'b0) begin n_fail++; $display("FAIL held_ped got %b exp 0", ped_button); end
    n_cmp++; if (ped_drop_count !== 8'd1) begin n_fail++; $display("FAIL held_drop got %0d exp 1", ped_drop_count); end
  endtask

  initial begin
    n_cmp   = 0;
    n_fail  = 0;
    reset   = 1'b0;
    ped_raw = 1'b0;
    em_raw  = 1'b0;
    ped_ack = 1'b0;
    em_ack  = 1'b0;
    #2;
    test_reset();
    test_bounce();
    test_holdoff();
    test_simultaneous();
    test_ack_corners();
    test_saturate_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/req_conditioner.md
Name: req_conditioner

Overview:
Upstream front end for the traffic-light FSM's pedestrian and emergency inputs.
- Synchronises and debounces the raw push-button lines.
- Converts each accepted press into a clean level request (`ped_button`, `em_button`) that rises exactly once per press and holds until the FSM acknowledges it.
- Enforces a pedestrian hold-off window and gives emergency priority over pedestrian.
- Counts rejected pedestrian presses for status display.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable cycles required before the debounced level changes; legal range 1..255.
- PED_HOLDOFF, 200: cycles after a pedestrian ack during which new pedestrian presses are rejected; 0 disables hold-off.
- DROP_W, 8: width of the rejected-press counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- ped_raw  in  1  raw pedestrian button, asynchronous, may bounce.
- em_raw  in  1  raw emergency button, asynchronous, may bounce.
- ped_ack  in  1  one-cycle pulse from FSM: pedestrian request serviced.
- em_ack  in  1  one-cycle pulse from FSM: emergency request serviced.
- ped_button  out  1  pedestrian request level to FSM.
- em_button  out  1  emergency request level to FSM.
- holdoff_active  out  1  high while the hold-off counter is non-zero.
- ped_drop_count  out  DROP_W  number of rejected pedestrian presses, saturating.

Behaviour:
- Reset (reset==0 at a clk edge):
  - Outputs: ped_button=0, em_button=0, holdoff_active=0, ped_drop_count=0.
  - Internal: synchroniser flops, debounced levels, debounce counters and hold-off counter all cleared to 0.
  - Reset mid-operation discards any pending request.
  - A raw input held high through reset release counts as a new press once the debounce delay has elapsed.
- Synchroniser: two flops per raw input (q1, q2).
- Debounce, per input, independent:
  - Each edge with q2 != db: if cnt == DEBOUNCE_CYCLES-1 then db<=q2 and cnt<=0; else cnt<=cnt+1.
  - Each edge with q2 == db: cnt<=0.
  - A glitch shorter than DEBOUNCE_CYCLES cycles (at q2) never changes db.
- Press event: db rising (db==1, db_prev==0). Release produces no event.
- Latency: raw high and stable before edge E0 gives an event visible in the cycle after E(1+DEBOUNCE_CYCLES). The corresponding request output rises at E(2+DEBOUNCE_CYCLES), i.e. DEBOUNCE_CYCLES+2 edges after first sampling.
- Emergency path:
  - em event sets em_button at the next edge.
  - em_ack clears it.
  - em event and em_ack in the same cycle: em_button stays/becomes 1 (set priority; an emergency is never lost).
  - em event while em_button already 1: no change.
- Pedestrian acceptance: a ped event is accepted only if holdoff_active==0, ped_button==0, em_button==0, and there is no em event in the same cycle. Accepted means ped_button<=1.
- Pedestrian rejection: a ped event failing any acceptance condition is rejected and increments ped_drop_count, which saturates at 2^DROP_W-1.
- ped_ack:
  - Clears ped_button.
  - Loads the hold-off counter with PED_HOLDOFF.
  - A ped event in the same cycle as ped_ack is rejected (counted).
- Hold-off counter:
  - Decrements by 1 each cycle while non-zero; stops at 0.
  - holdoff_active = (counter != 0), registered; it goes high the edge after ped_ack.
- Stray acks: em_ack while em_button==0 and ped_ack while ped_button==0 are ignored. A stray ped_ack does not load the hold-off counter.
- Simultaneous ped and em events in one cycle: em accepted, ped rejected and counted.
- An emergency pending does not clear an already-set ped_button; both may be high together.

Test Plan:
1. DEBOUNCE_CYCLES=4: reset low for 3 edges, then release → all outputs 0. Clean em_raw rise sampled at E0 → em_button=1 after E6. Pulse em_ack at E10 → em_button=0 after E10.
2. Bounce: ped_raw toggles high 3 cycles, low 1, high 3, then stable high → ped_button rises exactly once, 6 edges after the stable-high run begins; ped_drop_count stays 0.
3. PED_HOLDOFF=20: accepted press, ped_ack → holdoff_active high for 20 cycles. Second press debounced inside the window → ped_button stays 0, ped_drop_count=1. Third press after holdoff_active falls → ped_button=1.
4. ped_raw and em_raw rise on the same edge → em_button=1, ped_button=0, ped_drop_count=1. em_ack then a new ped press → ped_button=1.
5. New em event coincident with em_ack → em_button remains 1. A stray ped_ack with ped_button=0 → holdoff_active stays 0.
6. Saturation: DROP_W=2, five rejected presses → ped_drop_count=3. Reset asserted mid-request → ped_button=0, em_button=0, ped_drop_count=0 on the next edge.
